// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack fetch, valid/ready instruction hand-off, jump/jal/jr redirects.
// Optional FETCH_HALT_EN: accepting the all-zero instruction stops fetch until reset.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic               jal,
  input  logic               jr,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               link_we,
  output logic               halted
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] HALT  = 2'd3;
`endif

  logic [1:0]        state;
  logic              accept;
  logic              advance;
  logic              halt_instr;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] next_pc;

  assign accept   = (state == HOLD) && instr_ready;
  assign pc_plus1 = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FETCH_HALT_EN
  assign halt_instr = (instr == '0);
  assign halted     = (state == HALT);
`else
  assign halt_instr = 1'b0;
  assign halted     = 1'b0;
`endif

  // A halting accept freezes the PC and suppresses any redirect or link write.
  assign advance = accept && !halt_instr;

  always_comb begin
    next_pc = pc_plus1;
    if (jr)
      next_pc = jr_target;
    else if (jal || jump)
      next_pc = {pc[ADDR_W-1:12], instr[11:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (imem_ack) state <= HOLD;
        HOLD: begin
          if (accept) begin
`ifdef FETCH_HALT_EN
            state <= halt_instr ? HALT : FETCH;
`else
            state <= FETCH;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        HALT:  state <= HALT;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
    end else if (state == FETCH && imem_ack) begin
      instr <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= next_pc;
    end
  end

  // Link address is the return address of the accepted jal; it persists until the next jal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_we   <= 1'b0;
      link_addr <= '0;
    end else begin
      link_we <= advance && jal;
      if (advance && jal)
        link_addr <= pc_plus1;
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign opcode      = instr[INSTR_W-1 -: 4];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 16-bit single-cycle RISC core, directly upstream of `Control_Unit`. It holds the program counter, fetches one 16-bit word per instruction from instruction memory through a req/ack handshake, and presents the instruction and its 4-bit opcode with a valid/ready handshake. It also applies the jump, jal and jr redirects decoded for the accepted instruction, and produces the jal link address for the register file.

## Interface
- `ADDR_W`, 16: PC and instruction-memory word-address width.
- `INSTR_W`, 16: instruction width; opcode is `instr[INSTR_W-1 -: 4]`.
- `RESET_PC`, 16'h0000: PC value loaded at reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: fetch request; held until ack.
- `imem_addr` out ADDR_W: word address; equals the PC.
- `imem_rdata` in INSTR_W: fetched word; valid when `imem_ack` is high.
- `imem_ack` in 1: one-cycle fetch completion; may arrive in the request cycle.
- `instr` out INSTR_W: registered instruction.
- `opcode` out 4: `instr[15:12]`, feeds `Control_Unit`.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: downstream accepts `instr`.
- `jump`, `jal`, `jr` in 1 each: decoded redirect flags for the presented instruction.
- `jr_target` in ADDR_W: register-read target for jr.
- `pc` out ADDR_W: address of the presented instruction.
- `link_addr` out ADDR_W: return address (PC+1) of the last accepted jal.
- `link_we` out 1: one-cycle link-write strobe.
- `halted` out 1: fetch stopped. Present only with the configuration macro; otherwise tied 0.

## Operation
- The FSM has the states IDLE, FETCH and HOLD, plus HALT when the macro is enabled.
- IDLE: entered on reset. After reset deassertion it spends one cycle here, then moves to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=PC.
  - On `imem_ack`, capture `imem_rdata` into `instr` and go to HOLD.
  - Otherwise stay in FETCH.
- HOLD: `instr_valid`=1 and `instr` is held stable.
  - Accept is defined as `instr_valid && instr_ready`.
  - On accept, load the next PC and go to FETCH.
- Next-PC selection, sampled in the accept cycle only:
  - If `jr`: next PC = `jr_target`.
  - Else if `jal` or `jump`: next PC = {PC[15:12], `instr[11:0]`}.
  - Else: next PC = PC+1, modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
  - Priority is jr > jal > jump if more than one flag is set.
- Link write: on accept with `jal`=1, the next cycle has `link_we`=1 for exactly one cycle and `link_addr`=PC+1 (with wrap). `link_addr` holds its value until the next jal.
- Redirect flags outside the accept cycle are ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`pc`=RESET_PC.
  - `instr`=0, `opcode`=0, `instr_valid`=0.
  - `link_addr`=0, `link_we`=0, `halted`=0.
- Reset is asynchronous: asserting `rst_n` mid-operation drops `imem_req` and `instr_valid` immediately. An `imem_ack` arriving after reset, or in any state other than FETCH, is ignored.
- `imem_addr` stays stable for as long as `imem_req` is high.
- Latency:
  - Ack in cycle N → `instr_valid` in cycle N+1.
  - Accept in cycle M → `imem_req` with the new PC in cycle M+1.
  - With a zero-wait memory, throughput is one instruction per 2 cycles.
- Backpressure: while `instr_ready`=0 in HOLD, `instr`, `pc` and `imem_req`=0 are held indefinitely.
- `opcode` is combinational from the `instr` register.

## Configuration
- `FETCH_HALT_EN` defined:
  - Accepting `instr`==16'h0000 moves the FSM to HALT.
  - In HALT: `halted`=1, no further `imem_req`, `instr_valid`=0. Only reset leaves HALT.
  - A redirect flag set on the halt instruction is ignored.
- `FETCH_HALT_EN` undefined: 16'h0000 is fetched and advanced like any other instruction, and `halted` is constant 0.

## Test plan
- Sequential fetch: reset, then release; memory returns 16'h1123 and then 16'h2045 with ack in the request cycle; `instr_ready`=1 → `imem_addr` sequence 0,1,2; `instr_valid` high every 2nd cycle; `opcode` 1 then 2.
- Wait states and backpressure: ack delayed 3 cycles, `instr_ready` low 4 cycles → `imem_addr` stable during req; `instr` and `pc` held; no new req until accept.
- Jump/jal: at PC 16'h3005, instr 16'hA0F0 with `jump`=1 → next addr 16'h30F0. At PC 16'h3005, instr 16'h70F0 with `jal`=1 → next addr 16'h30F0, and `link_we` pulses once with `link_addr`=16'h3006.
- jr and wrap: `jr`=1, `jr_target`=16'hFFFF → fetch at 16'hFFFF; the following sequential fetch is at 16'h0000.
- Reset mid-fetch: `rst_n` low while `imem_req`=1, then ack arrives during reset → `imem_req`=0 immediately; nothing is captured; after release, fetch restarts at RESET_PC.
- `FETCH_HALT_EN`: memory returns 16'h0000 and it is accepted → `halted`=1 the next cycle and no `imem_req` for 20 cycles. Without the macro → fetch continues at PC+1.
